// File: rtl/fft_sys_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fft_sys_pkg
// Purpose  : Shared constants and types for the FFT test-system blocks:
//            default frame geometry, the squared-magnitude type, the framing
//            FSM state encoding and the magnitude pipeline depth.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fft_sys_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int FFT_N_DEF  = 256;
  localparam int IDX_W_DEF  = 8;

  // Sink-transfer to source_valid latency of the magnitude datapath.
  localparam int MAG_STAGES = 3;

  // re^2 + im^2 for default-width samples; always non-negative.
  typedef logic [2*DATA_W_DEF-1:0] mag_t;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } frame_state_t;

endpackage : fft_sys_pkg
`default_nettype wire

// File: rtl/fft_mag_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fft_mag_pipe
// Purpose  : Three-stage squared-magnitude datapath.
//            S1 registers the sample, S2 forms re*re and im*im, S3 adds them.
//            Valid/sop/eop/index ride alongside. All stages advance only when
//            en is high, so a stalled output stays stable and bubbles travel
//            as valid=0.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            en                  - global pipeline advance
//            in_valid/sop/eop    - sideband entering S1
//            in_index            - bin index entering S1
//            in_real/in_imag     - signed sample
//            out_valid/sop/eop   - sideband leaving S3
//            out_index, out_mag  - bin index and unsigned re^2+im^2
// Revision : 1.0 - initial release
// ============================================================================
module fft_mag_pipe #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic                       in_sop,
  input  logic                       in_eop,
  input  logic [IDX_W-1:0]           in_index,
  input  logic signed [DATA_W-1:0]   in_real,
  input  logic signed [DATA_W-1:0]   in_imag,
  output logic                       out_valid,
  output logic                       out_sop,
  output logic                       out_eop,
  output logic [IDX_W-1:0]           out_index,
  output logic [2*DATA_W-1:0]        out_mag
);

  logic                       s1_valid, s1_sop, s1_eop;
  logic [IDX_W-1:0]           s1_index;
  logic signed [DATA_W-1:0]   s1_re, s1_im;

  logic                       s2_valid, s2_sop, s2_eop;
  logic [IDX_W-1:0]           s2_index;
  logic signed [2*DATA_W-1:0] s2_rr, s2_ii;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_sop    <= 1'b0;
      s1_eop    <= 1'b0;
      s1_index  <= '0;
      s1_re     <= '0;
      s1_im     <= '0;
      s2_valid  <= 1'b0;
      s2_sop    <= 1'b0;
      s2_eop    <= 1'b0;
      s2_index  <= '0;
      s2_rr     <= '0;
      s2_ii     <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_index <= '0;
      out_mag   <= '0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s1_sop    <= in_sop;
      s1_eop    <= in_eop;
      s1_index  <= in_index;
      s1_re     <= in_real;
      s1_im     <= in_imag;

      s2_valid  <= s1_valid;
      s2_sop    <= s1_sop;
      s2_eop    <= s1_eop;
      s2_index  <= s1_index;
      // Full-width signed squares: (-2^(W-1))^2 = 2^(2W-2) still fits.
      s2_rr     <= s1_re * s1_re;
      s2_ii     <= s1_im * s1_im;

      out_valid <= s2_valid;
      out_sop   <= s2_sop;
      out_eop   <= s2_eop;
      out_index <= s2_index;
      // Both squares are non-negative; their sum peaks at 2^(2W-1), which
      // fits the unsigned 2W-bit result without a carry out.
      out_mag   <= $unsigned(s2_rr) + $unsigned(s2_ii);
    end
  end

endmodule : fft_mag_pipe
`default_nettype wire

// File: rtl/fft_bin_magnitude.sv
`default_nettype none
// ============================================================================
// Module   : fft_bin_magnitude
// Purpose  : Converts the FFT core's complex bin stream into a stream of
//            squared magnitudes tagged with bin index, enforcing frame
//            framing (sop/eop/length) and flagging malformed frames with a
//            one-cycle frame_error pulse.
//            Optional macro FFT_HALF_SPECTRUM_EN: forward only bins
//            0..FFT_N/2-1 (eop on FFT_N/2-1); framing still checks FFT_N.
// Ports    : clk, reset                 - clock, synchronous active-high reset
//            sink_valid/ready/sop/eop   - Avalon-ST input handshake/framing
//            sink_real/imag             - signed complex bin
//            sink_error                 - FFT core error code
//            source_valid/ready/sop/eop - Avalon-ST output handshake/framing
//            source_mag, source_index   - re^2+im^2 and bin index
//            frame_error                - registered one-cycle error pulse
// Revision : 1.0 - initial release
// ============================================================================
module fft_bin_magnitude
  import fft_sys_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FFT_N  = FFT_N_DEF,
  parameter int IDX_W  = IDX_W_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sink_valid,
  output logic                      sink_ready,
  input  logic                      sink_sop,
  input  logic                      sink_eop,
  input  logic signed [DATA_W-1:0]  sink_real,
  input  logic signed [DATA_W-1:0]  sink_imag,
  input  logic [1:0]                sink_error,
  output logic                      source_valid,
  input  logic                      source_ready,
  output logic                      source_sop,
  output logic                      source_eop,
  output logic [2*DATA_W-1:0]       source_mag,
  output logic [IDX_W-1:0]          source_index,
  output logic                      frame_error
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FFT_N - 1);
`ifdef FFT_HALF_SPECTRUM_EN
  localparam logic [IDX_W-1:0] HALF_LAST_IDX = IDX_W'(FFT_N / 2 - 1);
`endif

  logic             en;
  logic             xfer;
  frame_state_t     state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] bin_idx;
  logic             fwd, bin_sop, bin_eop, err_nxt;

  // A single global enable: the whole pipeline moves only when the output
  // register is empty or being consumed.
  assign en         = !source_valid || source_ready;
  assign sink_ready = en;
  assign xfer       = sink_valid && sink_ready;

  // Framing decisions are made per accepted bin; idx holds the index the
  // next in-frame bin will carry.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    fwd       = 1'b0;
    bin_idx   = idx;
    bin_sop   = 1'b0;
    bin_eop   = 1'b0;
    err_nxt   = 1'b0;

    if (xfer) begin
      err_nxt = (sink_error != 2'b00);
      if (sink_sop) begin
        // Start (or restart) of a frame; a restart abandons the old frame
        // without an eop and is itself an error.
        fwd     = 1'b1;
        bin_idx = '0;
        bin_sop = 1'b1;
        if (state == IN_FRAME) err_nxt = 1'b1;
        if (sink_eop || FFT_N == 1) begin
          bin_eop   = 1'b1;
          if (FFT_N != 1 || !sink_eop) err_nxt = 1'b1;
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          state_nxt = IN_FRAME;
          idx_nxt   = IDX_W'(1);
        end
      end else if (state == IDLE) begin
        // Orphan bin outside a frame: consumed and dropped.
        err_nxt = 1'b1;
      end else begin
        fwd     = 1'b1;
        bin_idx = idx;
        if (sink_eop || idx == LAST_IDX) begin
          // Either a real eop or a forced one at the last legal index; any
          // mismatch between the two means the frame length was wrong.
          bin_eop = 1'b1;
          if (!sink_eop || idx != LAST_IDX) err_nxt = 1'b1;
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end

`ifdef FFT_HALF_SPECTRUM_EN
      if (bin_idx[IDX_W-1]) fwd = 1'b0;
      if (bin_idx == HALF_LAST_IDX) bin_eop = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      frame_error <= 1'b0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      frame_error <= err_nxt;
    end
  end

  fft_mag_pipe #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mag_pipe (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .in_valid  (xfer && fwd),
    .in_sop    (bin_sop),
    .in_eop    (bin_eop),
    .in_index  (bin_idx),
    .in_real   (sink_real),
    .in_imag   (sink_imag),
    .out_valid (source_valid),
    .out_sop   (source_sop),
    .out_eop   (source_eop),
    .out_index (source_index),
    .out_mag   (source_mag)
  );

endmodule : fft_bin_magnitude
`default_nettype wire

// File: tb/tb_fft_bin_magnitude.sv
`default_nettype none
// ============================================================================
// Module   : tb_fft_bin_magnitude
// Purpose  : Self-checking bench for fft_bin_magnitude. A framing model
//            predicts forwarded bins (pushed to a scoreboard queue on each
//            accepted transfer) and the frame_error pulse for each transfer.
//            Build with FFT_HALF_SPECTRUM_EN to check the half-spectrum mode.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_fft_bin_magnitude;
  import fft_sys_pkg::*;

  localparam int DW = 16;
  localparam int N  = 256;
  localparam int IW = 8;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 sink_valid, sink_ready, sink_sop, sink_eop;
  logic signed [DW-1:0] sink_real, sink_imag;
  logic [1:0]           sink_error;
  logic                 source_valid, source_ready, source_sop, source_eop;
  logic [2*DW-1:0]      source_mag;
  logic [IW-1:0]        source_index;
  logic                 frame_error;

  always #5 clk = ~clk;

  fft_bin_magnitude #(.DATA_W(DW), .FFT_N(N), .IDX_W(IW)) dut (
    .clk          (clk),
    .reset        (reset),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .sink_real    (sink_real),
    .sink_imag    (sink_imag),
    .sink_error   (sink_error),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .source_mag   (source_mag),
    .source_index (source_index),
    .frame_error  (frame_error)
  );

  typedef struct {
    mag_t mag;
    int   idx;
    bit   sop;
    bit   eop;
  } exp_t;

  typedef struct {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
    logic [1:0]           err;
    mag_t                 mag;
  } vec_t;

  exp_t sbq[$];
  vec_t tab[9];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  bit m_inf = 0;
  int m_idx = 0;
  bit pend_err = 0;
  int rdy_mode = 0;
  int rdy_ph = 0;
  bit lat_arm = 0;
  int lat_start = -1;
  int lat_seen = -1;

  bit   have_hold = 0;
  exp_t hold;

  always @(posedge clk) cyc++;

  // Framing reference model: decides forwarding, output index/sop/eop and
  // frame_error for one accepted bin, plus the resulting model state.
  function automatic void model_step(input bit sop, input bit eop, input logic [1:0] e,
                                     output bit fwd, output int oidx, output bit osop,
                                     output bit oeop, output bit ferr,
                                     output bit n_inf, output int n_idx);
    fwd = 1; osop = 0; oeop = 0; ferr = (e != 2'b00);
    n_inf = m_inf; n_idx = m_idx; oidx = m_idx;
    if (sop) begin
      oidx = 0; osop = 1;
      if (m_inf) ferr = 1;
      if (eop) begin oeop = 1; ferr = 1; n_inf = 0; n_idx = 0; end
      else begin n_inf = 1; n_idx = 1; end
    end else if (!m_inf) begin
      fwd = 0; ferr = 1;
    end else if (eop) begin
      oeop = 1; if (m_idx != N - 1) ferr = 1; n_inf = 0; n_idx = 0;
    end else if (m_idx == N - 1) begin
      oeop = 1; ferr = 1; n_inf = 0; n_idx = 0;
    end else begin
      n_idx = m_idx + 1;
    end
`ifdef FFT_HALF_SPECTRUM_EN
    if (oidx >= N / 2) fwd = 0;
    if (oidx == N / 2 - 1) oeop = 1;
`endif
  endfunction

  task automatic chk_err();
    tests++;
    if (frame_error !== pend_err) begin
      fails++;
      $display("FAIL frame_error @cyc %0d: got %b expected %b", cyc, frame_error, pend_err);
    end
    pend_err = 0;
  endtask

  task automatic set_ready();
    if (rdy_mode == 0) source_ready = 1'b1;
    else begin
      source_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
      rdy_ph++;
    end
  endtask

  task automatic send(input bit sop, input bit eop, input logic signed [DW-1:0] re,
                      input logic signed [DW-1:0] im, input logic [1:0] e,
                      input bit use_tab = 0, input mag_t tab_mag = '0);
    bit fwd, osop, oeop, ferr, ninf, acc;
    int oidx, nidx;
    int guard = 0;
    longint r, i;
    exp_t x;
    model_step(sop, eop, e, fwd, oidx, osop, oeop, ferr, ninf, nidx);
    acc = 0;
    while (!acc) begin
      @(negedge clk);
      chk_err();
      set_ready();
      sink_valid = 1'b1; sink_sop = sop; sink_eop = eop;
      sink_real = re; sink_imag = im; sink_error = e;
      #1;
      acc = sink_ready;
      if (acc) begin
        pend_err = ferr;
        m_inf = ninf; m_idx = nidx;
        if (fwd) begin
          r = re; i = im;
          x.mag = use_tab ? tab_mag : mag_t'(r * r + i * i);
          x.idx = oidx; x.sop = osop; x.eop = oeop;
          sbq.push_back(x);
        end
        if (lat_arm && lat_start < 0) lat_start = cyc;
      end else begin
        guard++;
        if (guard > 50) begin
          tests++; fails++;
          $display("FAIL sink_ready timeout: got 0 expected 1 within 50 cycles");
          acc = 1;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk_err();
      set_ready();
      sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0; sink_error = 2'b00;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_err();
    reset = 1'b1; sink_valid = 1'b0; source_ready = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (source_valid !== 1'b0 || source_sop !== 1'b0 || source_eop !== 1'b0 ||
        source_mag !== '0 || source_index !== '0 || frame_error !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: got valid=%b sop=%b eop=%b mag=%h idx=%0d ferr=%b expected all 0",
               source_valid, source_sop, source_eop, source_mag, source_index, frame_error);
    end
    tests++;
    if (sink_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_sink_ready: got %b expected 1", sink_ready);
    end
    sbq.delete();
    m_inf = 0; m_idx = 0; pend_err = 0; have_hold = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Output monitor: scoreboard compare on each handshake, ready/stall
  // relation and output stability while stalled.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (!reset) begin
      tests++;
      if (sink_ready !== (!source_valid || source_ready)) begin
        fails++;
        $display("FAIL sink_ready_stall: got %b expected %b", sink_ready, !source_valid || source_ready);
      end
      if (have_hold) begin
        tests++;
        if (source_valid !== 1'b1 || source_mag !== hold.mag || int'(source_index) != hold.idx ||
            source_sop !== hold.sop || source_eop !== hold.eop) begin
          fails++;
          $display("FAIL stall_stable: got v=%b mag=%h idx=%0d expected v=1 mag=%h idx=%0d",
                   source_valid, source_mag, source_index, hold.mag, hold.idx);
        end
      end
      if (source_valid && source_ready) begin
        tests++;
        if (sbq.size() == 0) begin
          fails++;
          $display("FAIL unexpected_output: got idx=%0d mag=%h expected no output", source_index, source_mag);
        end else begin
          e = sbq.pop_front();
          if (source_mag !== e.mag || int'(source_index) != e.idx ||
              source_sop !== e.sop || source_eop !== e.eop) begin
            fails++;
            $display("FAIL bin_out: got mag=%h idx=%0d sop=%b eop=%b expected mag=%h idx=%0d sop=%b eop=%b",
                     source_mag, source_index, source_sop, source_eop, e.mag, e.idx, e.sop, e.eop);
          end
        end
        if (lat_arm) begin lat_seen = cyc; lat_arm = 0; end
      end
      have_hold = source_valid && !source_ready;
      hold.mag = source_mag; hold.idx = int'(source_index);
      hold.sop = source_sop; hold.eop = source_eop;
    end else begin
      have_hold = 0;
    end
  end

  initial begin
    int drain;
    tab[0] = '{16'sd3,      -16'sd4,     2'd0, 32'd25};
    tab[1] = '{-16'sd32768, -16'sd32768, 2'd0, 32'h8000_0000};
    tab[2] = '{16'sd32767,  16'sd0,      2'd0, 32'h3FFF_0001};
    tab[3] = '{16'sd0,      16'sd0,      2'd0, 32'h0000_0000};
    tab[4] = '{-16'sd1,     -16'sd1,     2'd1, 32'h0000_0002};
    tab[5] = '{16'sd32767,  16'sd32767,  2'd0, 32'h7FFE_0002};
    tab[6] = '{-16'sd32768, 16'sd32767,  2'd2, 32'h7FFF_0001};
    tab[7] = '{16'sd100,    -16'sd200,   2'd0, 32'd50000};
    tab[8] = '{16'sd0,      -16'sd32768, 2'd3, 32'h4000_0000};

    reset = 1'b1; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    sink_real = '0; sink_imag = '0; sink_error = 2'b00; source_ready = 1'b1;
    do_reset();

    // Single non-zero bin, with first-output latency measurement.
    lat_arm = 1; lat_start = -1; lat_seen = -1;
    for (int b = 0; b < N; b++)
      send(b == 0, b == N - 1, (b == 5) ? 16'sd3 : 16'sd0, (b == 5) ? -16'sd4 : 16'sd0, 2'b00);
    idle(8);
    tests++;
    if (lat_seen - lat_start != 3) begin
      fails++;
      $display("FAIL latency: got %0d expected 3", lat_seen - lat_start);
    end

    // Table vectors (extremes and sink_error codes) at the start of a frame.
    for (int b = 0; b < N; b++) begin
      if (b < 9) send(b == 0, 1'b0, tab[b].re, tab[b].im, tab[b].err, 1'b1, tab[b].mag);
      else       send(1'b0, b == N - 1, 16'sd0, 16'sd0, 2'b00);
    end
    idle(6);

    // Backpressure 1,0,0,1 on a random-data frame.
    rdy_mode = 1; rdy_ph = 0;
    for (int b = 0; b < N; b++)
      send(b == 0, b == N - 1, DW'($urandom), DW'($urandom), 2'b00);
    idle(12);
    rdy_mode = 0;
    idle(4);

    // Short frame (eop at 99), then a frame with no eop, then an orphan bin.
    for (int b = 0; b < 100; b++) send(b == 0, b == 99, DW'(b), 16'sd1, 2'b00);
    for (int b = 0; b < N; b++)   send(b == 0, 1'b0, 16'sd2, DW'(b), 2'b00);
    send(1'b0, 1'b0, 16'sd7, 16'sd7, 2'b00);
    idle(6);

    // Restart by sop at index 50, completed as a full frame.
    for (int b = 0; b < 50; b++) send(b == 0, 1'b0, 16'sd1, 16'sd1, 2'b00);
    for (int b = 0; b < N; b++)  send(1'b1 && b == 0, b == N - 1, -16'sd5, DW'(b), 2'b00);
    idle(6);

    // Reset in the middle of a frame, then a clean frame.
    for (int b = 0; b <= 120; b++) send(b == 0, 1'b0, 16'sd9, 16'sd9, 2'b00);
    do_reset();
    for (int b = 0; b < N; b++) send(b == 0, b == N - 1, DW'(b), -16'sd3, 2'b00);

    drain = 0;
    while (sbq.size() != 0 && drain < 200) begin idle(1); drain++; end
    idle(3);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d outputs still pending expected 0", sbq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_fft_bin_magnitude
`default_nettype wire
